// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and sizing helpers for the sequential divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  // Step counter width; never narrower than one bit so degenerate widths still elaborate
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] partial,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] new_partial,
  output logic         q_bit
);

  logic [W:0] p;

  // Trial subtraction on the shifted-in partial remainder; the result is always < divisor so W bits suffice
  always_comb begin
    p           = {partial, din};
    q_bit       = (p >= {1'b0, divisor});
    new_partial = W'(q_bit ? (p - {1'b0, divisor}) : p);
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] a_i,
  input  logic [DIVISOR_W-1:0]  b_i,
  output logic [DIVIDEND_W-1:0] q_o,
  output logic [DIVISOR_W-1:0]  r_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  dbz_o
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                  state_q, state_d;
  logic [DIVIDEND_W-1:0]   shift_q;
  logic [DIVISOR_W-1:0]    partial_q;
  logic [DIVISOR_W-1:0]    divisor_q;
  logic [CNT_W-1:0]        count_q;
  logic [DIVISOR_W-1:0]    step_partial;
  logic                    step_qbit;
  logic                    last_step;
  logic [DIVIDEND_W-1:0]   shift_next;

  assign last_step  = (count_q == '0);
  assign shift_next = {shift_q[DIVIDEND_W-2:0], step_qbit};

  div_step #(
    .W (DIVISOR_W)
  ) u_step (
    .partial     (partial_q),
    .din         (shift_q[DIVIDEND_W-1]),
    .divisor     (divisor_q),
    .new_partial (step_partial),
    .q_bit       (step_qbit)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; a zero divisor skips CALC entirely
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    case (state_q)
      IDLE: if (start_i) state_d = (b_i == '0) ? DONE : CALC;
      CALC: if (last_step) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers and result registers; results only change on the edge entering DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      partial_q <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      q_o       <= '0;
      r_o       <= '0;
      dbz_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q   <= a_i;
            divisor_q <= b_i;
            partial_q <= '0;
            count_q   <= CNT_W'(DIVIDEND_W - 1);
            if (b_i == '0) begin
              q_o   <= '1;
              r_o   <= '0;
              dbz_o <= 1'b1;
            end
          end
        end
        CALC: begin
          partial_q <= step_partial;
          shift_q   <= shift_next;
          if (last_step) begin
            q_o   <= shift_next;
            r_o   <= step_partial;
            dbz_o <= 1'b0;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  logic       clk_i;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] a_i;
  logic [3:0] b_i;
  logic [7:0] q_o;
  logic [3:0] r_o;
  logic       busy_o;
  logic       done_o;
  logic       dbz_o;

  int n_cmp;
  int n_err;
  int done_cnt;
  logic [7:0] prev_q;

  seq_divider #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .q_o     (q_o),
    .r_o     (r_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .dbz_o   (dbz_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (done_o !== 1'b1 && edges < 20) begin
      @(posedge clk_i); #1;
      edges++;
    end
  endtask

  task automatic do_op(input string name, input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input logic ed);
    int edges;
    @(negedge clk_i);
    a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check({name, " busy"}, 32'(busy_o), 32'd1);
    if (b != 0) check({name, " hold_q"}, 32'(q_o), 32'(prev_q));
    wait_done(edges);
    check({name, " latency"}, 32'(edges), (b == 0) ? 32'd1 : 32'd9);
    check({name, " q"}, 32'(q_o), 32'(eq));
    check({name, " r"}, 32'(r_o), 32'(er));
    check({name, " dbz"}, 32'(dbz_o), 32'(ed));
    prev_q = eq;
    @(posedge clk_i); #1;
    check({name, " done_pulse"}, 32'(done_o), 32'd0);
    check({name, " idle"}, 32'(busy_o), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int edges;
    int cnt0;
    logic [7:0] ra, mq;
    logic [3:0] rb, mr;

    n_cmp = 0; n_err = 0; done_cnt = 0; prev_q = 8'd0;
    rst_ni = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
    vecs[3] = '{8'd123, 4'd0,  8'd255, 4'd0, 1'b1};
    vecs[4] = '{8'd12,  4'd3,  8'd4,   4'd0, 1'b0};
    vecs[5] = '{8'd9,   4'd2,  8'd4,   4'd1, 1'b0};
    vecs[6] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0};
    vecs[7] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};

    repeat (2) @(posedge clk_i);
    #1;
    check("reset q", 32'(q_o), 32'd0);
    check("reset r", 32'(r_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset dbz", 32'(dbz_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Start during CALC must be ignored
    cnt0 = done_cnt;
    @(negedge clk_i); a_i = 8'd100; b_i = 4'd3; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1; a_i = 8'd50; b_i = 4'd5; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    wait_done(edges);
    check("midcalc done_seen", 32'(done_o), 32'd1);
    check("midcalc q", 32'(q_o), 32'd33);
    check("midcalc r", 32'(r_o), 32'd1);
    repeat (15) @(posedge clk_i);
    #1;
    check("midcalc done_count", 32'(done_cnt - cnt0), 32'd1);
    prev_q = 8'd33;

    // Reset in the middle of an operation
    cnt0 = done_cnt;
    @(negedge clk_i); a_i = 8'd200; b_i = 4'd7; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2; rst_ni = 1'b0;
    #1;
    check("abort q", 32'(q_o), 32'd0);
    check("abort r", 32'(r_o), 32'd0);
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort done", 32'(done_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i); rst_ni = 1'b1;
    repeat (12) @(posedge clk_i);
    #1;
    check("abort no_done", 32'(done_cnt - cnt0), 32'd0);
    check("abort idle", 32'(busy_o), 32'd0);
    prev_q = 8'd0;
    do_op("after_abort", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0);

    // Random operands against an arithmetic reference
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      mq = (rb == 0) ? 8'hFF : 8'(ra / rb);
      mr = (rb == 0) ? 4'd0 : 4'(ra % rb);
      do_op($sformatf("rnd%0d_%0d/%0d", i, ra, rb), ra, rb, mq, mr, rb == 0);
    end

    // Every nonzero-divisor pair back-to-back with start held high
    cnt0 = done_cnt;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        @(negedge clk_i);
        a_i = 8'(ai); b_i = 4'(bi); start_i = 1'b1;
        @(posedge clk_i); #1;
        wait_done(edges);
        if (q_o !== 8'(ai / bi) || r_o !== 4'(ai % bi) || edges != 9) begin
          check($sformatf("exh %0d/%0d q", ai, bi), 32'(q_o), 32'(ai / bi));
          check($sformatf("exh %0d/%0d r", ai, bi), 32'(r_o), 32'(ai % bi));
          check($sformatf("exh %0d/%0d latency", ai, bi), 32'(edges), 32'd9);
        end else begin
          n_cmp++;
        end
        @(posedge clk_i); #1;
      end
    end
    start_i = 1'b0;
    @(negedge clk_i);
    check("exh done_count", 32'(done_cnt - cnt0), 32'd3840);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor, producing quotient and remainder.
- Inverse companion of the existing combinational 4x4 multiplier; a product from that block fed back in with the same divisor returns the original operand, remainder 0.
- Resolves one quotient bit per clock, with a start/done handshake, for use by the lab datapath and top-level display logic.

Parameters:
- DIVIDEND_W, 8, width of dividend and quotient.
- DIVISOR_W, 4, width of divisor and remainder.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  request pulse; accepted only when busy_o=0.
- a_i  in  DIVIDEND_W  dividend; sampled on the accepting edge only.
- b_i  in  DIVISOR_W  divisor; sampled on the accepting edge only.
- q_o  out  DIVIDEND_W  quotient, registered.
- r_o  out  DIVISOR_W  remainder, registered.
- busy_o  out  1  high in CALC and DONE.
- done_o  out  1  one-cycle pulse when q_o/r_o are updated.
- dbz_o  out  1  divide-by-zero flag for the last result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; q_o=0, r_o=0, busy_o=0, done_o=0, dbz_o=0; internal counter and working registers 0.
- States:
  - IDLE: start_i=1 latches a_i/b_i. If b_i=0, go to DONE; otherwise load shift register=a_i, partial remainder=0, count=DIVIDEND_W-1, go to CALC.
  - CALC, once per edge:
    - p = {partial[DIVISOR_W-1:0], shift MSB}, DIVISOR_W+1 bits.
    - If p >= divisor: partial = p - divisor and shift in quotient bit 1; else partial = p and shift in 0.
    - Shift register moves left by one.
    - When count=0, go to DONE; otherwise decrement count.
  - DONE: for one cycle, drive done_o=1, with q_o/r_o/dbz_o valid and updated on the edge entering DONE. Next edge returns to IDLE.
- Latency: done_o is high in the cycle after DIVIDEND_W+1 edges following the accepting edge (9 for defaults). For divide-by-zero, done_o is high after 1 edge.
- Divide by zero result: q_o = all ones, r_o=0, dbz_o=1. Any nonzero divisor result clears dbz_o.
- q_o/r_o/dbz_o hold their values from DONE until the next DONE. They are not cleared on accept.
- start_i while busy_o=1 (CALC or DONE) is ignored; there is no queueing. An operand change mid-operation has no effect.
- start_i held high continuously: a new operation is accepted on the first IDLE edge, giving one idle cycle between operations.
- Reset mid-operation aborts immediately with all outputs at reset values. No done_o is issued for the aborted operation.
- Width rule: partial remainder is DIVISOR_W+1 bits internally; the final remainder is < divisor, so it fits in DIVISOR_W. There is no overflow case.
- Counter width: $clog2(DIVIDEND_W).
- No X propagation: every register has a reset value.

Decomposition:
- Shared package seq_divider_pkg:
  - state enum {IDLE, CALC, DONE}, 2-bit encoding.
  - Localparam for counter width.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: partial, next dividend bit, divisor.
  - Outputs: new partial, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- a=200, b=7, one start pulse -> busy_o high next cycle; done_o after 9 edges with q_o=28, r_o=4, dbz_o=0.
- a=255, b=15 -> q_o=17, r_o=0. Then a=5, b=9 -> q_o=0, r_o=5 (dividend smaller than divisor).
- a=123, b=0 -> done_o after 1 edge with q_o=255, r_o=0, dbz_o=1. Next a=12, b=3 clears dbz_o, giving q_o=4, r_o=0.
- Start 100/3, then pulse start_i with 50/5 during CALC -> only q_o=33, r_o=1 reported; single done_o pulse; no second result.
- Start 200/7, deassert rst_ni at cycle 4 -> outputs 0 immediately, no done_o. After release, 9/2 -> q_o=4, r_o=1.
- Exhaustive: all 256x15 nonzero-divisor pairs back-to-back with start_i held high -> every result matches a/b and a%b; done_o count equals 3840.
